// File: rtl/alu_pkg.sv
// Widths, opcodes, flag indices and FSM encoding shared by the Jac1-8 execute stage,
// ALU_J and the decoder.
package alu_pkg;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned NUM_REGS      = 4;
  localparam int unsigned REG_ADDR_BITS = 2;
  localparam int unsigned OPCODE_BITS   = 5;
  localparam int unsigned PARAM_BITS    = 8;
  localparam int unsigned STATUS_BITS   = 3;

  localparam int unsigned FLAG_OVF  = 0;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 2;

  typedef logic [OPCODE_BITS-1:0] opcode_t;

  localparam opcode_t OP_NOP = 5'h00;
  localparam opcode_t OP_ADD = 5'h01;
  localparam opcode_t OP_SUB = 5'h02;
  localparam opcode_t OP_AND = 5'h03;
  localparam opcode_t OP_OR  = 5'h04;
  localparam opcode_t OP_NOT = 5'h05;
  localparam opcode_t OP_XOR = 5'h06;
  localparam opcode_t OP_SHL = 5'h07;
  localparam opcode_t OP_SHR = 5'h08;
  localparam opcode_t OP_VAL = 5'h09;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } state_e;

  // Instruction fields held from handshake until writeback
  typedef struct packed {
    opcode_t                  opcode;
    logic [REG_ADDR_BITS-1:0] dst;
    logic [PARAM_BITS-1:0]    param;
  } instr_t;

  function automatic logic is_alu_op(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file: two operand read ports, one debug read port,
// one synchronous write port, async clear.
module alu_regfile
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [REG_ADDR_BITS-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [REG_ADDR_BITS-1:0] raddr1,
  input  logic [REG_ADDR_BITS-1:0] raddr2,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    rdata1_c,
  output logic [DATA_WIDTH-1:0]    rdata2_c,
  output logic [DATA_WIDTH-1:0]    dbg_data_c
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1_c   = regs_q[raddr1];
  assign rdata2_c   = regs_q[raddr2];
  assign dbg_data_c = regs_q[dbg_addr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for ALU_J: IDLE -> ISSUE -> CAPTURE -> WB, one instruction per 4 cycles.
// Optional macro ALU_CTRL_PERF_EN adds the exec_count / ovf_count performance counters.
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OPCODE_BITS-1:0]   instr_opcode,
  input  logic [REG_ADDR_BITS-1:0] instr_dst,
  input  logic [REG_ADDR_BITS-1:0] instr_src1,
  input  logic [REG_ADDR_BITS-1:0] instr_src2,
  input  logic [PARAM_BITS-1:0]    instr_param,
  output logic [OPCODE_BITS-1:0]   alu_opcode,
  output logic [DATA_WIDTH-1:0]    alu_operand1,
  output logic [DATA_WIDTH-1:0]    alu_operand2,
  output logic [PARAM_BITS-1:0]    alu_param,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic [STATUS_BITS-1:0]   alu_status,
  output logic [STATUS_BITS-1:0]   flags,
  output logic                     done,
  output logic                     err,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_data
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [15:0]              exec_count,
  output logic [7:0]               ovf_count
`endif
);
  state_e                 state_q, state_d;
  instr_t                 instr_q;
  logic [DATA_WIDTH-1:0]  res_q, rd1_c, rd2_c, wb_data_c;
  logic [STATUS_BITS-1:0] stat_q, flags_d;
  logic                   hs_c, wb_we_c, illegal_c;

  assign hs_c      = instr_valid & instr_ready;
  assign illegal_c = instr_q.opcode > OP_VAL;

  alu_regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (wb_we_c),
    .waddr     (instr_q.dst),
    .wdata     (wb_data_c),
    .raddr1    (instr_src1),
    .raddr2    (instr_src2),
    .dbg_addr  (dbg_addr),
    .rdata1_c  (rd1_c),
    .rdata2_c  (rd2_c),
    .dbg_data_c(dbg_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (hs_c) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WB;
      ST_WB:      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Writeback decode: VAL bypasses the ALU, NOP and illegal opcodes commit nothing
  always_comb begin
    wb_we_c   = 1'b0;
    wb_data_c = res_q;
    flags_d   = flags;
    if (state_q == ST_WB) begin
      if (instr_q.opcode == OP_VAL) begin
        wb_we_c            = 1'b1;
        wb_data_c          = instr_q.param[DATA_WIDTH-1:0];
        flags_d            = '0;
        flags_d[FLAG_ZERO] = (instr_q.param == '0);
      end else if (is_alu_op(instr_q.opcode)) begin
        wb_we_c = 1'b1;
        flags_d = stat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_ready  <= 1'b1;
      instr_q      <= '0;
      res_q        <= '0;
      stat_q       <= '0;
      flags        <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      alu_opcode   <= OP_NOP;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_param    <= '0;
    end else begin
      instr_ready <= (state_d == ST_IDLE);
      done        <= (state_d == ST_WB);
      err         <= (state_d == ST_WB) && illegal_c;
      flags       <= flags_d;
      if (hs_c) begin
        instr_q <= '{opcode: instr_opcode, dst: instr_dst, param: instr_param};
      end
      if (state_q == ST_CAPTURE) begin
        res_q  <= alu_result;
        stat_q <= alu_status;
      end
      // ALU inputs live only through ISSUE and CAPTURE
      if (hs_c) begin
        alu_opcode   <= instr_opcode;
        alu_operand1 <= rd1_c;
        alu_operand2 <= rd2_c;
        alu_param    <= instr_param;
      end else if (state_d != ST_CAPTURE) begin
        alu_opcode   <= OP_NOP;
        alu_operand1 <= '0;
        alu_operand2 <= '0;
        alu_param    <= '0;
      end
    end
  end

`ifdef ALU_CTRL_PERF_EN
  // Saturating counters sampled on the writeback cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_count <= '0;
      ovf_count  <= '0;
    end else if (state_q == ST_WB) begin
      if (wb_we_c && (exec_count != 16'hFFFF)) exec_count <= exec_count + 16'd1;
      if ((flags_d[FLAG_OVF] | flags_d[FLAG_UNF]) && (ovf_count != 8'hFF))
        ovf_count <= ovf_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: stand-in ALU_J, instruction-level architectural model,
// per-cycle compare plus hand-computed register/flag expectations.
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [4:0] instr_opcode = '0;
  logic [1:0] instr_dst = '0, instr_src1 = '0, instr_src2 = '0;
  logic [7:0] instr_param = '0;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand1, alu_operand2, alu_param;
  logic [7:0] alu_result;
  logic [2:0] alu_status;
  logic [2:0] flags;
  logic       done, err;
  logic [1:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_fail = 0;

  alu_exec_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_dst(instr_dst),
    .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_param(instr_param),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_param(alu_param),
    .alu_result(alu_result), .alu_status(alu_status),
    .flags(flags), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial forever #5 clk = ~clk;

  // ALU_J behaviour: returns {zero, underflow, overflow, result}
  function automatic logic [10:0] alu_j(input logic [4:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] p);
    logic [8:0] w;
    logic [7:0] r;
    logic       ov, un;
    ov = 1'b0; un = 1'b0; r = '0; w = '0;
    case (op)
      5'h01: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; ov = w[8]; end
      5'h02: begin r = a - b; un = (a < b); end
      5'h03: r = a & b;
      5'h04: r = a | b;
      5'h05: r = ~b;
      5'h06: r = a ^ b;
      5'h07: r = a << p;
      5'h08: r = a >> p;
      default: r = '0;
    endcase
    return {(r == 8'd0), un, ov, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_j(alu_opcode, alu_operand1, alu_operand2, alu_param);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: one instruction in flight, committed 3 edges after acceptance
  int         cyc = 0;
  int         hs_edge = 0;
  bit         m_busy = 1'b0;
  logic [4:0] m_op = '0;
  logic [1:0] m_dst = '0;
  logic [7:0] m_a = '0, m_b = '0, m_p = '0;
  logic [7:0] m_regs [4];
  logic [2:0] m_flags = '0;
  int         m_acc = 0;
  int         obs_done = 0;

  always @(posedge clk or negedge reset_n) begin : model
    logic [10:0] sr;
    if (!reset_n) begin
      cyc = 0; m_busy = 1'b0; hs_edge = 0; m_flags = '0; m_op = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (instr_valid) begin
          m_busy = 1'b1; hs_edge = cyc; m_acc++;
          m_op = instr_opcode; m_dst = instr_dst; m_p = instr_param;
          m_a = m_regs[instr_src1]; m_b = m_regs[instr_src2];
        end
      end else if (cyc == hs_edge + 3) begin
        m_busy = 1'b0;
        sr = alu_j(m_op, m_a, m_b, m_p);
        if (m_op == 5'h09) begin
          m_regs[m_dst] = m_p;
          m_flags = {(m_p == 8'd0), 2'b00};
        end else if (m_op >= 5'h01 && m_op <= 5'h08) begin
          m_regs[m_dst] = sr[7:0];
          m_flags = sr[10:8];
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic exp_done;
    if (reset_n) begin
      exp_done = m_busy && (cyc == hs_edge + 2);
      chk("ready", 32'(instr_ready), 32'(!m_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_done && (m_op >= 5'h0A)));
      if (m_busy && (cyc <= hs_edge + 1)) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        chk("alu_operand1", 32'(alu_operand1), 32'(m_a));
        chk("alu_operand2", 32'(alu_operand2), 32'(m_b));
        chk("alu_param", 32'(alu_param), 32'(m_p));
      end else begin
        chk("alu_idle", 32'({alu_opcode, alu_operand1, alu_operand2, alu_param}), 32'd0);
      end
      chk("flags", 32'(flags), 32'(m_flags));
      chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
      if (done === 1'b1) obs_done++;
    end
  end

  logic last_err;

  task automatic do_instr(input logic [4:0] op, input logic [1:0] d, input logic [1:0] s1,
                          input logic [1:0] s2, input logic [7:0] p);
    int n;
    int hs;
    n = 0;
    while (instr_ready !== 1'b1 && n < 16) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr_opcode = op; instr_dst = d;
    instr_src1 = s1; instr_src2 = s2; instr_param = p;
    @(posedge clk); #1;
    hs = cyc;
    instr_valid = 1'b0;
    // fields change while busy and must be ignored
    instr_opcode = 5'h1F; instr_dst = ~d; instr_src1 = ~s1; instr_param = ~p;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    chk("done_lat", 32'(cyc - hs), 32'd2);
    last_err = err;
    @(posedge clk); #1;
  endtask

  task automatic lit_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
    chk({name, "_model"}, 32'(m_regs[a]), 32'(exp));
  endtask

  task automatic lit_flags(input string name, input logic [2:0] exp);
    chk(name, 32'(flags), 32'(exp));
    chk({name, "_model"}, 32'(m_flags), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, done0;
    #22 reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_alu", 32'({alu_opcode, alu_operand1, alu_operand2, alu_param}), 32'd0);
    lit_reg("rst_r3", 2'd3, 8'h00);
    @(posedge clk); #1;

    // ADD with carry out
    do_instr(5'h09, 2'd0, 2'd0, 2'd0, 8'd255);
    do_instr(5'h09, 2'd1, 2'd0, 2'd0, 8'd2);
    do_instr(5'h01, 2'd2, 2'd0, 2'd1, 8'd0);
    lit_reg("add_r2", 2'd2, 8'd1);
    lit_flags("add_flags", 3'b001);

    // SUB with borrow, then AND to zero
    do_instr(5'h09, 2'd0, 2'd0, 2'd0, 8'd14);
    do_instr(5'h09, 2'd1, 2'd0, 2'd0, 8'd15);
    do_instr(5'h02, 2'd3, 2'd0, 2'd1, 8'd0);
    lit_reg("sub_r3", 2'd3, 8'd255);
    lit_flags("sub_flags", 3'b010);
    do_instr(5'h09, 2'd2, 2'd0, 2'd0, 8'd0);
    do_instr(5'h03, 2'd3, 2'd3, 2'd2, 8'd0);
    lit_reg("and_r3", 2'd3, 8'd0);
    lit_flags("and_flags", 3'b100);

    // Shifts
    do_instr(5'h09, 2'd0, 2'd0, 2'd0, 8'h76);
    do_instr(5'h07, 2'd1, 2'd0, 2'd0, 8'd1);
    lit_reg("shl_r1", 2'd1, 8'hEC);
    lit_flags("shl_flags", 3'b000);
    do_instr(5'h08, 2'd2, 2'd1, 2'd0, 8'h33);
    lit_reg("shr_r2", 2'd2, 8'h00);
    lit_flags("shr_flags", 3'b100);

    // NOT takes operand2
    do_instr(5'h05, 2'd3, 2'd2, 2'd1, 8'd0);
    lit_reg("not_r3", 2'd3, 8'h13);

    // NOP and illegal opcode leave state alone
    do_instr(5'h09, 2'd1, 2'd0, 2'd0, 8'h55);
    do_instr(5'h09, 2'd2, 2'd0, 2'd0, 8'h00);
    do_instr(5'h00, 2'd1, 2'd0, 2'd0, 8'h00);
    chk("nop_err", 32'(last_err), 32'd0);
    lit_flags("nop_flags", 3'b100);
    do_instr(5'h1F, 2'd1, 2'd0, 2'd0, 8'hAA);
    chk("ill_err", 32'(last_err), 32'd1);
    lit_reg("ill_r1", 2'd1, 8'h55);
    lit_flags("ill_flags", 3'b100);

    // Valid held high: one acceptance per 4 cycles, dst == src1
    acc0 = m_acc; done0 = obs_done;
    instr_valid = 1'b1; instr_opcode = 5'h01; instr_dst = 2'd0;
    instr_src1 = 2'd0; instr_src2 = 2'd1; instr_param = 8'd0;
    repeat (16) @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_acc", 32'(m_acc - acc0), 32'd4);
    chk("stream_done", 32'(obs_done - done0), 32'd4);
    lit_reg("stream_r0", 2'd0, 8'hCA);

    // Reset during CAPTURE aborts the ADD
    @(posedge clk); #1;
    done0 = obs_done;
    instr_valid = 1'b1; instr_opcode = 5'h01; instr_dst = 2'd2;
    instr_src1 = 2'd0; instr_src2 = 2'd1; instr_param = 8'd0;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rel_ready", 32'(instr_ready), 32'd1);
    lit_reg("rel_r2", 2'd2, 8'h00);
    lit_flags("rel_flags", 3'b000);
    repeat (6) @(posedge clk);
    #1;
    chk("rel_no_done", 32'(obs_done - done0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
